spart_rx_loader: RTL and testbench
==================================

# spart_rx_loader

Serial program/data loader that sits directly upstream of the SPART control stage. It receives a length-prefixed word stream over an 8N1 serial line and packs byte pairs into 16-bit words. The words are stored in an internal word buffer. The buffer is exposed through the same synchronous read port (addr, enable, data_out) that the control stage uses to fetch load data, so the fixed ROM loader is replaced with a host-downloadable image.

## Interface
- CLK_DIV, 434: clock cycles per serial bit (50 MHz / 115200); legal range 8..65535.
- DEPTH, 512: buffer depth in 16-bit words (power of two).
- AW, $clog2(DEPTH): buffer address width.
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  serial receive line, idle high, asynchronous to clk.
- enable  in  1  read enable for the read port.
- addr  in  16  read word address.
- data_out  out  16  registered read data.
- load_done  out  1  high once the declared word count has been stored.
- word_count  out  AW+1  words stored so far (header excluded).
- frame_err  out  1  sticky; set on any bad stop bit.

## Operation
- rxd passes through a 2-flop synchronizer; all decisions use the synced value.
- Byte receiver FSM states and transitions:
  - IDLE: a falling edge moves to START.
  - START: sample at CLK_DIV/2. A low sample moves to DATA; a high sample is a false start and returns to IDLE with no byte.
  - DATA: 8 samples, one every CLK_DIV cycles, LSB first.
  - STOP: sample after a further CLK_DIV cycles. A high sample emits a byte_valid pulse. A low sample sets frame_err, discards the byte, and holds in STOP until the synced rxd is high, then goes to IDLE.
- Word assembler:
  - The first byte of each pair is the low byte and the second is the high byte.
  - A discarded byte does not toggle the pair phase.
- Loader phases:
  - HDR: the first assembled word is the length N.
  - LOAD: each following word is written to buffer[wr_ptr], then wr_ptr increments and word_count increments.
  - DONE: entered when word_count == min(N, DEPTH).
- Boundary conditions:
  - N > DEPTH: the first DEPTH words are stored and the rest are discarded. load_done asserts after word DEPTH; later bytes are ignored.
  - N == 0: load_done asserts the cycle after the header completes.
  - In DONE, all received bytes are ignored until reset. frame_err still updates.
- Read port:
  - enable high: data_out <= buffer[addr[AW-1:0]] if addr[15:AW] == 0, otherwise 16'h0000.
  - enable low: data_out holds its value.
  - A read and a write to the same address in the same cycle return the old data (read-first).
  - Reads are legal in every phase.
- Reset, async, any time including mid-byte or mid-load:
  - data_out=0, load_done=0, word_count=0, frame_err=0.
  - FSM returns to IDLE, pair phase to low byte, loader to HDR.
  - Buffer contents are not cleared.

## Timing
- Start-edge detect to the mid-start sample: CLK_DIV/2 cycles. Each later sample follows CLK_DIV cycles after the previous one.
- byte_valid pulses for one cycle, the cycle after the stop sample.
- Buffer write and the word_count update occur one cycle after the high-byte byte_valid.
- load_done rises the cycle after the final write, or after the header for N == 0.
- Read latency is 1 cycle: data_out is valid on the clk edge after enable is sampled high.
- Back-to-back frames (stop bit directly followed by the next start bit) must be received without loss.

## Structure
- Package spart_pkg holds:
  - CLK_DIV default and DEPTH default.
  - typedef rx_state_t {IDLE, START, DATA, STOP}.
  - typedef load_phase_t {HDR, LOAD, DONE}.
- Sub-module spart_rx contains the synchronizer, baud counter, and byte FSM. Its outputs are byte[7:0], byte_valid, and frame_err_pulse.
- Top level holds the pair assembler, loader FSM, DEPTH x 16 buffer (inferred BRAM, read-first), and output registers.

## Test plan
All scenarios run with CLK_DIV=16.
- Reset behaviour: drive rst high, then low, with rxd idle -> all outputs 0 and load_done stays 0 for 10000 cycles.
- Basic load: send bytes 03 00, 34 12, 78 56, BC 9A. Expect load_done rises one cycle after the third write and word_count=3. Then read addr 0,1,2,3 with enable -> 1234, 5678, 9ABC, then old buffer content, each 1 cycle after the read.
- False start and framing: a 4-cycle low glitch on rxd produces no byte. A frame with the stop bit low sets frame_err=1, the pair phase is unchanged, and the next valid frames still assemble correctly.
- Overflow with DEPTH=8: header 0x000A followed by 10 words. Expect 8 words stored, load_done after the 8th word, word_count=8, and the last 2 words ignored.
- Read port edges: addr=0x0200 (above DEPTH=512) -> data_out 0000. A read and write to the same address in one cycle -> old data. enable low -> data_out held.
- Mid-load reset: assert rst during the data bits of the 2nd word. Expect all outputs 0; a new header 0x0001 plus 1 word then loads at addr 0 and load_done rises.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared defaults and state encodings for the SPART serial loader.
package spart_pkg;

  localparam int unsigned CLK_DIV_DEF = 434;
  localparam int unsigned DEPTH_DEF   = 512;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {HDR, LOAD, DONE} load_phase_t;

endpackage

// File: rtl/spart_rx_loader_if.sv
// Synchronous buffer read port shared with the SPART control stage.
interface spart_rx_loader_if;
  logic        enable;
  logic [15:0] addr;
  logic [15:0] data_out;

  modport master (output enable, output addr, input data_out);
  modport slave  (input enable, input addr, output data_out);
endinterface

// File: rtl/spart_rx.sv
// 8N1 byte receiver: rxd synchronizer, baud counter and byte FSM.
module spart_rx
  import spart_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_pulse_o
);

  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLK_DIV - 1);

  rx_state_t   state_q;
  logic        sync1_q, sync2_q, prev_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        valid_q, ferr_q, bad_q;

  // Synchronize rxd and run the start/data/stop sampling state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (prev_q && !sync2_q) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            bit_q <= '0;
            state_q <= sync2_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          // After a bad stop bit, wait for the line to return high before hunting for a new start.
          if (bad_q) begin
            if (sync2_q) begin
              bad_q   <= 1'b0;
              state_q <= IDLE;
            end
          end else if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (sync2_q) begin
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q <= 1'b1;
              bad_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_o            = shift_q;
  assign byte_valid_o      = valid_q;
  assign frame_err_pulse_o = ferr_q;

endmodule

// File: rtl/spart_rx_loader.sv
// Length-prefixed serial image loader feeding a read-first word buffer.
module spart_rx_loader
  import spart_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  spart_rx_loader_if.slave   rd,
  output logic               load_done,
  output logic [AW:0]        word_count,
  output logic               frame_err
);

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ferr;

  spart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk               (clk),
    .rst               (rst),
    .rxd_i             (rxd),
    .byte_o            (rx_byte),
    .byte_valid_o      (rx_valid),
    .frame_err_pulse_o (rx_ferr)
  );

  load_phase_t phase_q;
  logic        hi_phase_q;
  logic [7:0]  lo_q;
  logic [AW:0] cnt_q, cnt_d, lim_q, lim_d;
  logic        done_q, ferr_q;
  logic [15:0] word_w;
  logic        wr_en;
  logic [15:0] mem_q [DEPTH];
  logic [15:0] dout_q;

  // Assembled word, write strobe, and the clamped length min(N, DEPTH).
  always_comb begin
    word_w = {rx_byte, lo_q};
    wr_en  = rx_valid && hi_phase_q && (phase_q == LOAD);
    cnt_d  = cnt_q + {{AW{1'b0}}, 1'b1};
    if (32'(word_w) > DEPTH) lim_d = DEPTH[AW:0];
    else                     lim_d = word_w[AW:0];
  end

  // Pair assembler and loader phase tracking; bytes are ignored once DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= HDR;
      hi_phase_q <= 1'b0;
      lo_q       <= '0;
      cnt_q      <= '0;
      lim_q      <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      if (rx_ferr)          ferr_q <= 1'b1;
      if (phase_q == DONE)  done_q <= 1'b1;
      if (rx_valid && phase_q != DONE) begin
        if (!hi_phase_q) begin
          lo_q       <= rx_byte;
          hi_phase_q <= 1'b1;
        end else begin
          hi_phase_q <= 1'b0;
          if (phase_q == HDR) begin
            lim_q   <= lim_d;
            phase_q <= (lim_d == '0) ? DONE : LOAD;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == lim_q) phase_q <= DONE;
          end
        end
      end
    end
  end

  // Buffer write port; the word index is the running word count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[cnt_q[AW-1:0]] <= word_w;
  end

  // Registered read port: read-first, out-of-range addresses read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else if (rd.enable) begin
      if (rd.addr[15:AW] == '0) dout_q <= mem_q[rd.addr[AW-1:0]];
      else                      dout_q <= '0;
    end
  end

  assign rd.data_out = dout_q;
  assign load_done   = done_q;
  assign word_count  = cnt_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_spart_rx_loader.sv
// Scoreboard bench for spart_rx_loader: DEPTH=512 instance and DEPTH=8 overflow instance.
module tb_spart_rx_loader;

  localparam int unsigned CD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rxd_a, rxd_b;
  logic       ld_a, ld_b, fe_a, fe_b;
  logic [9:0] wc_a;
  logic [3:0] wc_b;

  spart_rx_loader_if ifa();
  spart_rx_loader_if ifb();

  spart_rx_loader #(.CLK_DIV(CD)) dut_a (
    .clk(clk), .rst(rst_a), .rxd(rxd_a), .rd(ifa),
    .load_done(ld_a), .word_count(wc_a), .frame_err(fe_a)
  );

  spart_rx_loader #(.CLK_DIV(CD), .DEPTH(8)) dut_b (
    .clk(clk), .rst(rst_b), .rxd(rxd_b), .rd(ifb),
    .load_done(ld_b), .word_count(wc_b), .frame_err(fe_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected read data and expected word_count at each load_done rise.
  logic [15:0] rdq_a[$];
  logic [15:0] rdq_b[$];
  int          wcq_a[$];
  int          wcq_b[$];
  bit          mon_a_on = 1'b1;

  always @(posedge clk) begin : rd_mon_a
    logic en;
    logic [15:0] e;
    en = ifa.enable;
    #1;
    if (en && mon_a_on) begin
      if (rdq_a.size() == 0) chk("rd_a_unexpected", 32'(ifa.data_out), 32'hDEAD_BEEF);
      else begin
        e = rdq_a.pop_front();
        chk("rd_a", 32'(ifa.data_out), 32'(e));
      end
    end
  end

  always @(posedge clk) begin : rd_mon_b
    logic en;
    logic [15:0] e;
    en = ifb.enable;
    #1;
    if (en) begin
      if (rdq_b.size() == 0) chk("rd_b_unexpected", 32'(ifb.data_out), 32'hDEAD_BEEF);
      else begin
        e = rdq_b.pop_front();
        chk("rd_b", 32'(ifb.data_out), 32'(e));
      end
    end
  end

  int         last_a = 0, last_b = 0;
  logic [9:0] pwc_a = '0;
  logic [3:0] pwc_b = '0;
  logic       pld_a = 1'b0, pld_b = 1'b0;

  always @(posedge clk) begin : ld_mon_a
    #1;
    if (wc_a !== pwc_a) last_a = cyc;
    if (ld_a === 1'b1 && !pld_a) begin
      if (wcq_a.size() == 0) chk("ld_a_unexpected", 32'(ld_a), 32'd0);
      else begin
        chk("ld_a_count", 32'(wc_a), 32'(wcq_a.pop_front()));
        chk("ld_a_latency", 32'(cyc - last_a), 32'd1);
      end
    end
    pwc_a = wc_a;
    pld_a = ld_a;
  end

  always @(posedge clk) begin : ld_mon_b
    #1;
    if (wc_b !== pwc_b) last_b = cyc;
    if (ld_b === 1'b1 && !pld_b) begin
      if (wcq_b.size() == 0) chk("ld_b_unexpected", 32'(ld_b), 32'd0);
      else begin
        chk("ld_b_count", 32'(wc_b), 32'(wcq_b.pop_front()));
        chk("ld_b_latency", 32'(cyc - last_b), 32'd1);
      end
    end
    pwc_b = wc_b;
    pld_b = ld_b;
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] d, input logic stop);
    drive(sel, 1'b0);
    repeat (CD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      repeat (CD) @(negedge clk);
    end
    drive(sel, stop);
    repeat (CD) @(negedge clk);
    if (!stop) begin
      drive(sel, 1'b1);
      repeat (2 * CD) @(negedge clk);
    end
  endtask

  task automatic send_word(input bit sel, input logic [15:0] w);
    send_byte(sel, w[7:0], 1'b1);
    send_byte(sel, w[15:8], 1'b1);
  endtask

  task automatic wait_ld(input bit sel, input int budget);
    int k;
    k = 0;
    while (((sel ? ld_b : ld_a) !== 1'b1) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(sel ? "ld_b_wait" : "ld_a_wait", 32'(sel ? ld_b : ld_a), 32'd1);
  endtask

  task automatic rd(input bit sel, input logic [15:0] a, input logic [15:0] exp);
    @(negedge clk);
    if (sel) begin
      ifb.enable = 1'b1; ifb.addr = a; rdq_b.push_back(exp);
    end else begin
      ifa.enable = 1'b1; ifa.addr = a; rdq_a.push_back(exp);
    end
    @(negedge clk);
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
  endtask

  initial begin : watchdog
    wait (cyc > 60000);
    $display("FAIL watchdog: cycle %0d exceeded budget 60000", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [15:0] w;
    int k;
    rst_a = 1'b1; rst_b = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1;
    ifa.enable = 1'b0; ifa.addr = '0;
    ifb.enable = 1'b0; ifb.addr = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    chk("rst_dout", 32'(ifa.data_out), 32'd0);
    chk("rst_ld",   32'(ld_a), 32'd0);
    chk("rst_wc",   32'(wc_a), 32'd0);
    chk("rst_fe",   32'(fe_a), 32'd0);
    repeat (10000) @(negedge clk);
    chk("idle_ld", 32'(ld_a), 32'd0);
    chk("idle_wc", 32'(wc_a), 32'd0);

    // Preload addr0..4 = 1111..5555 so later reads have known old contents.
    wcq_a.push_back(5);
    send_word(1'b0, 16'h0005);
    for (int i = 1; i <= 5; i++) send_word(1'b0, 16'(16'h1111 * i));
    wait_ld(1'b0, 100);
    rd(1'b0, 16'd4, 16'h5555);

    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("rst2_dout", 32'(ifa.data_out), 32'd0);
    chk("rst2_ld",   32'(ld_a), 32'd0);
    chk("rst2_wc",   32'(wc_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;

    // Short low glitch must not start a byte.
    rxd_a = 1'b0;
    repeat (4) @(negedge clk);
    rxd_a = 1'b1;
    repeat (3 * CD) @(negedge clk);
    chk("glitch_fe", 32'(fe_a), 32'd0);
    chk("glitch_wc", 32'(wc_a), 32'd0);

    // Basic load with a bad-stop frame between the two halves of 0x1234.
    wcq_a.push_back(3);
    send_word(1'b0, 16'h0003);
    send_byte(1'b0, 8'h34, 1'b1);
    send_byte(1'b0, 8'hEE, 1'b0);
    chk("ferr_set", 32'(fe_a), 32'd1);
    send_byte(1'b0, 8'h12, 1'b1);
    send_word(1'b0, 16'h5678);
    send_word(1'b0, 16'h9ABC);
    wait_ld(1'b0, 100);
    chk("basic_wc", 32'(wc_a), 32'd3);
    chk("ferr_sticky", 32'(fe_a), 32'd1);
    rd(1'b0, 16'd0, 16'h1234);
    rd(1'b0, 16'd1, 16'h5678);
    rd(1'b0, 16'd2, 16'h9ABC);
    rd(1'b0, 16'd3, 16'h4444);
    rd(1'b0, 16'h0200, 16'h0000);
    rd(1'b0, 16'hFFFF, 16'h0000);

    rd(1'b0, 16'd0, 16'h1234);
    ifa.addr = 16'd2;
    repeat (3) @(negedge clk);
    chk("hold_dout", 32'(ifa.data_out), 32'h1234);

    // Bytes after DONE are ignored.
    send_word(1'b0, 16'h2211);
    send_word(1'b0, 16'h4433);
    chk("done_wc", 32'(wc_a), 32'd3);
    rd(1'b0, 16'd3, 16'h4444);

    // Reset in the data bits of the second word.
    send_word(1'b0, 16'h0005);
    rxd_a = 1'b0;
    repeat (CD) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd_a = 1'b1;
      repeat (CD) @(negedge clk);
    end
    rxd_a = 1'b0;
    repeat (CD / 2) @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("midrst_dout", 32'(ifa.data_out), 32'd0);
    chk("midrst_ld",   32'(ld_a), 32'd0);
    chk("midrst_wc",   32'(wc_a), 32'd0);
    chk("midrst_fe",   32'(fe_a), 32'd0);
    rxd_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    repeat (2 * CD) @(negedge clk);

    // Reload one word at addr 0 while reading addr 0 every cycle (read-first).
    wcq_a.push_back(1);
    send_word(1'b0, 16'h0001);
    mon_a_on = 1'b0;
    ifa.addr = 16'd0;
    ifa.enable = 1'b1;
    fork
      send_word(1'b0, 16'hA55A);
      begin
        k = 0;
        while (wc_a != 10'd1 && k < 600) begin
          @(posedge clk);
          #1;
          k++;
        end
        chk("rw_seen", 32'(wc_a), 32'd1);
        chk("rw_old", 32'(ifa.data_out), 32'h1234);
        @(posedge clk);
        #1;
        chk("rw_new", 32'(ifa.data_out), 32'hA55A);
      end
    join
    @(negedge clk);
    ifa.enable = 1'b0;
    mon_a_on = 1'b1;
    wait_ld(1'b0, 100);
    chk("reload_wc", 32'(wc_a), 32'd1);
    rd(1'b0, 16'd0, 16'hA55A);
    rd(1'b0, 16'd1, 16'h5678);

    // DEPTH=8 overflow: header 10, only the first 8 words land.
    wcq_b.push_back(8);
    send_word(1'b1, 16'h000A);
    for (int i = 0; i < 10; i++) begin
      w = {8'hB0 + 8'(i), 8'h10 + 8'(i)};
      send_word(1'b1, w);
    end
    wait_ld(1'b1, 100);
    chk("ovf_wc", 32'(wc_b), 32'd8);
    for (int i = 0; i < 8; i++) begin
      w = {8'hB0 + 8'(i), 8'h10 + 8'(i)};
      rd(1'b1, 16'(i), w);
    end
    rd(1'b1, 16'd8, 16'h0000);

    repeat (4) @(negedge clk);
    chk("rdq_a_drained", 32'(rdq_a.size()), 32'd0);
    chk("rdq_b_drained", 32'(rdq_b.size()), 32'd0);
    chk("wcq_a_drained", 32'(wcq_a.size()), 32'd0);
    chk("wcq_b_drained", 32'(wcq_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
